// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and width helpers for the FIFO write arbiter.
//   - arb_state_t : two-state arbiter FSM encoding (no owner / burst owner)
//   - *_width()   : $clog2-based widths for producer index, occupancy and beat count
//   - *_DEF       : default parameter values used by the arbiter and its picker
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    localparam int NREQ_DEF  = 32'sd4;
    localparam int WIDTH_DEF = 32'sd8;
    localparam int DEPTH_DEF = 32'sd8;
    localparam int BURST_DEF = 32'sd4;

    // Producer index width; a single producer still needs one bit.
    function automatic int id_width(input int nreq);
        return (nreq > 32'sd1) ? $clog2(nreq) : 32'sd1;
    endfunction

    // Occupancy must represent 0..DEPTH inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 32'sd1;
    endfunction

    // Beat counter must represent 0..BURST inclusive.
    function automatic int beat_width(input int burst);
        return $clog2(burst + 32'sd1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker.
//   req   : request vector, one bit per producer
//   last  : index of the previous owner; search starts at last+1 and wraps
//   found : at least one request bit is set
//   idx   : first requesting index at or after last+1 (modulo NREQ)
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic            found,
    output logic [IDW-1:0]  idx
);

    // One spare bit so last+offset (at most 2*NREQ-1) never overflows before the wrap.
    logic [IDW:0] cand_s;

    // Walk offsets from farthest to nearest so the nearest requester is written last and wins.
    always_comb begin
        found  = 1'b0;
        idx    = last;
        cand_s = '0;
        for (int off = NREQ; off >= 1; off--) begin
            cand_s = {1'b0, last} + (IDW+1)'(off);
            cand_s = (cand_s >= (IDW+1)'(NREQ)) ? (cand_s - (IDW+1)'(NREQ)) : cand_s;
            found  = found | req[cand_s[IDW-1:0]];
            idx    = req[cand_s[IDW-1:0]] ? cand_s[IDW-1:0] : idx;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-locked write arbiter in front of a fifo_sync write port.
//   clk, reset   : single clock, synchronous active-high reset
//   req_valid    : per-producer valid
//   req_data     : producer i data in bits [i*WIDTH +: WIDTH]
//   req_ready    : combinational per-producer ready (only the owner can be ready)
//   fifo_full    : FIFO full flag, used as a secondary write gate
//   fifo_rd_ack  : one pulse per word removed from the FIFO
//   fifo_wr_en   : registered write strobe, one cycle after the handshake
//   fifo_din     : registered write data
//   grant_valid  : a burst grant is held
//   grant_id     : current or last owner
//   occupancy    : local count of words in the FIFO (credit counter)
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int BURST = BURST_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*WIDTH-1:0]       req_data,
    output logic [NREQ-1:0]             req_ready,
    input  logic                        fifo_full,
    input  logic                        fifo_rd_ack,
    output logic                        fifo_wr_en,
    output logic [WIDTH-1:0]            fifo_din,
    output logic                        grant_valid,
    output logic [id_width(NREQ)-1:0]   grant_id,
    output logic [occ_width(DEPTH)-1:0] occupancy
);

    localparam int IDW = id_width(NREQ);
    localparam int OCW = occ_width(DEPTH);
    localparam int BCW = beat_width(BURST);

    // After reset the search starts at NREQ-1+1, giving producer 0 first priority.
    localparam logic [IDW-1:0] LAST_RST  = IDW'(NREQ - 1);
    localparam logic [OCW-1:0] OCC_MAX   = OCW'(DEPTH);
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(BURST - 1);

    arb_state_t         state_r;
    arb_state_t         state_next_s;
    logic [IDW-1:0]     owner_r;
    logic [IDW-1:0]     last_r;
    logic [BCW-1:0]     beat_cnt_r;
    logic [OCW-1:0]     occupancy_r;
    logic               wr_en_r;
    logic [WIDTH-1:0]   din_r;

    logic               pick_found_s;
    logic [IDW-1:0]     pick_idx_s;
    logic               owner_valid_s;
    logic [WIDTH-1:0]   owner_data_s;
    logic               can_wr_s;
    logic               xfer_s;
    logic               release_s;
    logic               ack_eff_s;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req_valid),
        .last  (last_r),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    assign owner_valid_s = req_valid[owner_r];
    assign owner_data_s  = req_data[int'(owner_r) * WIDTH +: WIDTH];

    // Credit gate uses the pre-update count, so an ack never frees a slot in its own cycle.
    assign can_wr_s  = (state_r == ST_BURST) && (occupancy_r < OCC_MAX) && !fifo_full;
    assign xfer_s    = can_wr_s && owner_valid_s;
    // A credit stall keeps the grant; only a dropped valid or the final beat ends the burst.
    assign release_s = (state_r == ST_BURST) &&
                       (!owner_valid_s || (xfer_s && (beat_cnt_r == BEAT_LAST)));
    // Acks arriving with an empty count are spurious and dropped.
    assign ack_eff_s = fifo_rd_ack && (occupancy_r != '0);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic: grant on any request, drop back to IDLE on release.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_next_s = ST_BURST;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (release_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BURST;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: only the owner sees ready, and only while credit is available.
    always_comb begin
        req_ready = '0;
        case (state_r)
            ST_IDLE: begin
                req_ready = '0;
            end
            ST_BURST: begin
                req_ready[owner_r] = can_wr_s;
            end
            default: begin
                req_ready = '0;
            end
        endcase
    end

    // Owner, round-robin pointer and beat counter bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_r    <= '0;
            last_r     <= LAST_RST;
            beat_cnt_r <= '0;
        end else begin
            if ((state_r == ST_IDLE) && pick_found_s) begin
                owner_r    <= pick_idx_s;
                beat_cnt_r <= '0;
            end else if (xfer_s) begin
                beat_cnt_r <= beat_cnt_r + BCW'(1);
            end
            if (release_s) begin
                last_r <= owner_r;
            end
        end
    end

    // Credit counter: counts accepted handshakes, not the delayed write strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy_r <= '0;
        end else begin
            case ({xfer_s, ack_eff_s})
                2'b10:   occupancy_r <= occupancy_r + OCW'(1);
                2'b01:   occupancy_r <= occupancy_r - OCW'(1);
                default: occupancy_r <= occupancy_r;
            endcase
        end
    end

    // FIFO write port registers; reset drops any write still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_r <= 1'b0;
            din_r   <= '0;
        end else begin
            wr_en_r <= xfer_s;
            if (xfer_s) begin
                din_r <= owner_data_s;
            end
        end
    end

    assign fifo_wr_en  = wr_en_r;
    assign fifo_din    = din_r;
    assign grant_valid = (state_r == ST_BURST);
    assign grant_id    = owner_r;
    assign occupancy   = occupancy_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scoreboard bench for fifo_wr_arbiter (NREQ=4, WIDTH=8, DEPTH=8, BURST=4).
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int BURST = 4;

    logic             clk;
    logic             reset;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]  req_ready;
    logic             fifo_full;
    logic             fifo_rd_ack;
    logic             fifo_wr_en;
    logic [WIDTH-1:0] fifo_din;
    logic             grant_valid;
    logic [1:0]       grant_id;
    logic [3:0]       occupancy;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc_n = 0;
    int          rem[NREQ];
    logic [7:0]  nxt[NREQ];
    logic        auto_ack;
    logic        last_wr;
    logic [9:0]  exp_q[$];
    int          wr_cyc_q[$];

    fifo_wr_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .BURST (BURST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_rd_ack (fifo_rd_ack),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_din    (fifo_din),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .occupancy   (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (rem[i] != 0);
            req_data[i*WIDTH +: WIDTH] = nxt[i];
        end
    endtask

    task automatic push_exp(input int id, input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({2'(id), 8'(base + 8'(k))});
        end
    endtask

    task automatic mon_write();
        logic [9:0] e;
        if (fifo_wr_en === 1'b1) begin
            wr_cyc_q.push_back(cyc_n);
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_bad++;
                $error("FAIL wr_unexpected: observed id=%0d din=%02h expected no write", grant_id, fifo_din);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_word", 32'({grant_id, fifo_din}), 32'(e));
            end
        end
    endtask

    // One clock: sample at negedge, advance producers just after posedge.
    task automatic cyc();
        logic [NREQ-1:0] hs;
        @(negedge clk);
        hs      = req_valid & req_ready;
        last_wr = fifo_wr_en;
        mon_write();
        chk("occ_bound", 32'(occupancy <= 4'd8), 32'd1);
        @(posedge clk);
        #1;
        cyc_n++;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) begin
                rem[i]--;
                nxt[i]++;
            end
        end
        fifo_rd_ack = auto_ack & last_wr;
        drive_inputs();
    endtask

    function automatic bit busy();
        bit b;
        b = (exp_q.size() != 0);
        for (int i = 0; i < NREQ; i++) begin
            b = b | (rem[i] != 0);
        end
        return b;
    endfunction

    task automatic drain(input string tag);
        for (int k = 0; k < 300; k++) begin
            if (!busy()) break;
            cyc();
        end
        chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_gaps(input string tag);
        for (int n = 1; n < wr_cyc_q.size(); n++) begin
            chk(tag, 32'(wr_cyc_q[n] - wr_cyc_q[n-1]), (n % BURST == 0) ? 32'd2 : 32'd1);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        auto_ack  = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < NREQ; i++) rem[i] = 0;
        drive_inputs();
        cyc();
        cyc();
        reset = 1'b0;
        exp_q.delete();
        wr_cyc_q.delete();
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        fifo_full   = 1'b0;
        fifo_rd_ack = 1'b0;
        auto_ack    = 1'b0;
        last_wr     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0;
            nxt[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        req_valid = 4'hF;
        #1;
        chk("rst_grant_valid", 32'(grant_valid), 32'd0);
        chk("rst_grant_id",    32'(grant_id),    32'd0);
        chk("rst_occupancy",   32'(occupancy),   32'd0);
        chk("rst_wr_en",       32'(fifo_wr_en),  32'd0);
        chk("rst_din",         32'(fifo_din),    32'd0);
        chk("rst_ready",       32'(req_ready),   32'd0);
        do_reset();

        // Single producer, six words with acks: 4 words, one gap, 2 words.
        auto_ack = 1'b1;
        rem[0] = 6;
        nxt[0] = 8'h10;
        push_exp(0, 8'h10, 6);
        drive_inputs();
        drain("a");
        chk("a_count", 32'(wr_cyc_q.size()), 32'd6);
        chk_gaps("a_gap");
        do_reset();

        // All producers continuously valid: order 0,1,2,3,0,1,2,3 in bursts of 4.
        auto_ack = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 8;
            nxt[i] = 8'h80 + 8'(16 * i);
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                push_exp(i, 8'(8'h80 + 8'(16 * i) + 8'(4 * r)), 4);
            end
        end
        drive_inputs();
        drain("b");
        chk("b_count", 32'(wr_cyc_q.size()), 32'd32);
        chk_gaps("b_gap");
        do_reset();

        // No acks: credit limit stops at DEPTH, one ack admits exactly one more word.
        rem[1] = 12;
        nxt[1] = 8'h20;
        push_exp(1, 8'h20, 9);
        drive_inputs();
        repeat (20) cyc();
        chk("c_writes_full",  32'(wr_cyc_q.size()), 32'd8);
        chk("c_occ_full",     32'(occupancy),       32'd8);
        chk("c_ready_full",   32'(req_ready),       32'd0);
        chk("c_grant_held",   32'(grant_valid),     32'd1);
        chk("c_grant_id",     32'(grant_id),        32'd1);
        fifo_rd_ack = 1'b1;
        cyc();
        chk("c_occ_after_ack",   32'(occupancy), 32'd7);
        chk("c_ready_after_ack", 32'(req_ready), 32'd2);
        repeat (10) cyc();
        chk("c_writes_final", 32'(wr_cyc_q.size()), 32'd9);
        chk("c_occ_final",    32'(occupancy),       32'd8);
        chk("c_sb_empty",     32'(exp_q.size()),    32'd0);
        do_reset();

        // Owner drops valid after two beats; next requester after it is granted.
        rem[1] = 2;
        nxt[1] = 8'h30;
        rem[3] = 4;
        nxt[3] = 8'h50;
        push_exp(1, 8'h30, 2);
        push_exp(3, 8'h50, 4);
        drive_inputs();
        cyc();
        chk("d_first_valid", 32'(grant_valid), 32'd1);
        chk("d_first_id",    32'(grant_id),    32'd1);
        cyc();
        cyc();
        cyc();
        chk("d_released",    32'(grant_valid), 32'd0);
        cyc();
        chk("d_next_valid",  32'(grant_valid), 32'd1);
        chk("d_next_id",     32'(grant_id),    32'd3);
        drain("d");
        do_reset();

        // Transfer and ack together at occupancy 5 leave it at 5.
        rem[2] = 7;
        nxt[2] = 8'h60;
        push_exp(2, 8'h60, 7);
        drive_inputs();
        repeat (7) cyc();
        chk("e_occ_pre",  32'(occupancy), 32'd5);
        fifo_rd_ack = 1'b1;
        cyc();
        chk("e_occ_same", 32'(occupancy), 32'd5);
        cyc();
        chk("e_occ_inc",  32'(occupancy), 32'd6);
        drain("e");
        do_reset();
        fifo_rd_ack = 1'b1;
        cyc();
        chk("e_ack_at_zero", 32'(occupancy), 32'd0);

        // FIFO full gates ready without dropping the grant.
        fifo_full = 1'b1;
        rem[0] = 1;
        nxt[0] = 8'h70;
        push_exp(0, 8'h70, 1);
        drive_inputs();
        cyc();
        cyc();
        chk("full_ready", 32'(req_ready),   32'd0);
        chk("full_grant", 32'(grant_valid), 32'd1);
        fifo_full = 1'b0;
        drain("full");
        do_reset();

        // Reset in the middle of a burst (beat_cnt = 2).
        rem[1] = 1;
        nxt[1] = 8'h90;
        rem[2] = 6;
        nxt[2] = 8'hA0;
        push_exp(1, 8'h90, 1);
        push_exp(2, 8'hA0, 2);
        drive_inputs();
        repeat (6) cyc();
        chk("f_pre_valid", 32'(grant_valid), 32'd1);
        chk("f_pre_id",    32'(grant_id),    32'd2);
        reset  = 1'b1;
        rem[0] = 2;
        nxt[0] = 8'hC0;
        drive_inputs();
        cyc();
        chk("f_rst_wr_en", 32'(fifo_wr_en),  32'd0);
        chk("f_rst_din",   32'(fifo_din),    32'd0);
        chk("f_rst_gv",    32'(grant_valid), 32'd0);
        chk("f_rst_gid",   32'(grant_id),    32'd0);
        chk("f_rst_occ",   32'(occupancy),   32'd0);
        chk("f_rst_ready", 32'(req_ready),   32'd0);
        reset = 1'b0;
        push_exp(0, 8'hC0, 2);
        push_exp(2, nxt[2], rem[2]);
        cyc();
        chk("f_next_valid", 32'(grant_valid), 32'd1);
        chk("f_next_id",    32'(grant_id),    32'd0);
        drain("f");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one `fifo_sync` write port among `NREQ` producers, using a valid/ready handshake per producer. Grants are burst-locked for up to `BURST` beats. A local occupancy counter provides credit-based backpressure, because the FIFO's own `full` flag lags by one cycle. The block sits directly in front of the FIFO write side; the FIFO read side reports each dequeued word back through `fifo_rd_ack`.

## Interface
- `NREQ`, 4: number of producers (2..16).
- `WIDTH`, 8: data width; must match the FIFO's `WIDTH`.
- `DEPTH`, 8: FIFO depth; sets the credit limit.
- `BURST`, 4: maximum beats per grant (≥1).
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  producer i has a word.
- `req_data`  in  NREQ*WIDTH  producer i data in bits [i*WIDTH +: WIDTH].
- `req_ready`  out  NREQ  combinational; transfer happens when `req_valid[i] && req_ready[i]`.
- `fifo_full`  in  1  FIFO `full` flag; secondary write gate.
- `fifo_rd_ack`  in  1  one pulse per word actually removed from the FIFO.
- `fifo_wr_en`  out  1  registered write strobe to the FIFO.
- `fifo_din`  out  WIDTH  registered write data.
- `grant_valid`  out  1  a burst grant is held.
- `grant_id`  out  clog2(NREQ)  current or last owner.
- `occupancy`  out  clog2(DEPTH)+1  local count of words in the FIFO.

## Operation
- Two states. IDLE: no owner, all `req_ready` = 0. BURST: one owner.
- IDLE → BURST when any `req_valid` is high.
  - Owner is the first valid index searched from `last+1` upward, wrapping modulo `NREQ`.
  - `beat_cnt` is cleared on entry.
- In BURST, `can_wr = (occupancy < DEPTH) && !fifo_full`.
  - `req_ready[owner] = can_wr`; all other `req_ready` bits = 0.
- On each transfer: `fifo_wr_en` and `fifo_din` are registered next cycle, and `beat_cnt` increments.
- BURST → IDLE, setting `last = owner`, in either case:
  - the transfer that makes `beat_cnt == BURST`;
  - `req_valid[owner] == 0` in any BURST cycle.
- A credit stall (`can_wr = 0`) holds the grant. It is not a release.
- `occupancy_next = occupancy + xfer − fifo_rd_ack`.
  - `xfer` is the accepted handshake, not the delayed `fifo_wr_en`.
  - `fifo_rd_ack` while `occupancy == 0` is ignored (saturate at 0).
- Simultaneous transfer and ack: the counter is unchanged. The ack does not free a credit in the same cycle; gating uses the pre-update count.
- Reset applied mid-burst discards the in-flight registered write: `fifo_wr_en` = 0 on the next edge, and the FIFO is reset alongside.

## Timing
- Reset values:
  - state IDLE, `last` = NREQ−1 (producer 0 has first priority);
  - `grant_valid` 0, `grant_id` 0, `beat_cnt` 0, `occupancy` 0;
  - `fifo_wr_en` 0, `fifo_din` 0, `req_ready` all 0.
- Arbitration costs one cycle: valid at cycle t gives the grant at t+1, with the first transfer possible at t+1.
- Data reaches the FIFO write port one cycle after the handshake.
- Peak throughput is BURST words per BURST+1 cycles under contention. A single producer holding `valid` gets BURST words, one idle cycle, then continues.
- `occupancy` never exceeds DEPTH. `fifo_wr_en` is never asserted while the FIFO holds DEPTH words.

## Structure
- Package `fifo_arb_pkg`:
  - state enum {IDLE, BURST};
  - width constants derived via `$clog2` for `NREQ`, `DEPTH`, `BURST`.
- Sub-module `rr_pick`: combinational rotating-priority picker, taking a request vector and `last` and returning `found` and `idx`.
- Top level: FSM, beat counter, occupancy counter, output registers.

## Test plan
- Single producer 0 sends 6 words 0x10..0x15, with `fifo_rd_ack` pulsed after each write: FIFO receives 0x10..0x13, one gap cycle, then 0x14..0x15; `grant_id` = 0 throughout.
- All four producers valid continuously, BURST=4: grant order 0,1,2,3,0, each burst exactly 4 words with one idle cycle between bursts.
- No acks, DEPTH=8: exactly 8 writes accepted, `occupancy` = 8, `req_ready` = 0. One `fifo_rd_ack` → `occupancy` 7 → exactly one more write.
- Owner drops `req_valid` after 2 beats: grant released that cycle, and the next valid requester after the owner is granted the following cycle.
- Transfer and `fifo_rd_ack` in the same cycle at `occupancy` = 5 → stays 5. Ack at `occupancy` = 0 → stays 0.
- Assert `reset` mid-burst with `beat_cnt` = 2: next cycle all outputs are at their reset values, and producer 0 wins the next arbitration.
